// File: rtl/uart_prog_loader.sv
// ---------------------------------------------------------------------------
// uart_prog_loader
//
// Serial program loader for the single-cycle MIPS CPU. Receives 8N1 UART
// frames, assembles little-endian 32-bit words and writes them into the
// instruction ROM or the data RAM through one shared write port. While a
// load is in progress the CPU is held in reset through prog_mode.
//
// Frame: A5, region, adr lo, adr hi, count lo, count hi, count*4 payload
// bytes. A 5A byte in place of a frame header ends the load.
//
// Optional feature macro: UART_LOADER_CKSUM_EN
//   When defined, every frame carries a trailing byte equal to the XOR of
//   all frame bytes after A5. A mismatch sends the loader to its error
//   state. Words that were already written are not rolled back.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//   ADDR_W        word-address width of each target memory
//   GAP_CYCLES    max idle cycles between bytes inside a frame
//
// Ports:
//   clock      system clock
//   rst        synchronous, active-high reset
//   rx         asynchronous UART line, idle high
//   start_pg   level request to enter programming mode
//   prog_mode  high while loading (ORed into CPU reset)
//   mem_wen    one-cycle write strobe
//   mem_sel    0 = instruction ROM, 1 = data RAM
//   mem_adr    word address
//   mem_dat    write data
//   done       high from a successful load until next start_pg or rst
//   err        sticky error flag
// ---------------------------------------------------------------------------
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_W       = 14,
    parameter int GAP_CYCLES   = 1000000
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              rx,
    input  logic              start_pg,
    output logic              prog_mode,
    output logic              mem_wen,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_dat,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [3:0] P_IDLE     = 4'd0;
    localparam logic [3:0] P_WAIT_HDR = 4'd1;
    localparam logic [3:0] P_REGION   = 4'd2;
    localparam logic [3:0] P_ADR_LO   = 4'd3;
    localparam logic [3:0] P_ADR_HI   = 4'd4;
    localparam logic [3:0] P_CNT_LO   = 4'd5;
    localparam logic [3:0] P_CNT_HI   = 4'd6;
    localparam logic [3:0] P_DATA     = 4'd7;
    localparam logic [3:0] P_DONE     = 4'd8;
    localparam logic [3:0] P_ERROR    = 4'd9;
`ifdef UART_LOADER_CKSUM_EN
    localparam logic [3:0] P_CKSUM    = 4'd10;
    localparam logic [3:0] END_STATE  = P_CKSUM;
`else
    localparam logic [3:0] END_STATE  = P_WAIT_HDR;
`endif

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_shift;
    logic             rx_valid;
    logic             rx_ferr;

    logic [3:0]        state;
    logic              start_prev;
    logic              region;
    logic [7:0]        adr_lo;
    logic [7:0]        cnt_lo;
    logic [ADDR_W-1:0] adr_cnt;
    logic [15:0]       words_left;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;
    logic [GAP_W-1:0]  gap_cnt;
    logic              gap_active;
    logic              timeout;
`ifdef UART_LOADER_CKSUM_EN
    logic [7:0]        cksum;
`endif

    // Two-flop synchroniser plus one more stage so a falling edge can be
    // seen as "was high, now low" on clean, synchronous samples.
    always_ff @(posedge clock) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // 8N1 receiver. A start bit is confirmed half a bit after the falling
    // edge; a line that is high again by then was a glitch. rx_shift holds
    // the received byte until the next byte's data bits start shifting in,
    // which is long after the parser has consumed it.
    always_ff @(posedge clock) begin
        if (rst) begin
            rx_state <= R_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= R_START;
                        clk_cnt  <= '0;
                    end
                end
                R_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        bit_cnt  <= '0;
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            rx_state <= R_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= R_IDLE;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // The inter-byte timeout only runs once a frame header has been seen;
    // waiting for the next header or for start_pg may take arbitrarily long.
`ifdef UART_LOADER_CKSUM_EN
    assign gap_active = ((state >= P_REGION) && (state <= P_DATA)) || (state == P_CKSUM);
`else
    assign gap_active = (state >= P_REGION) && (state <= P_DATA);
`endif
    assign timeout = gap_active && (gap_cnt == GAP_LAST);

    always_ff @(posedge clock) begin
        if (rst || rx_valid || !gap_active) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

`ifdef UART_LOADER_CKSUM_EN
    // Running XOR of every byte after the A5 header; the trailer byte is
    // compared against the value accumulated before it arrives.
    always_ff @(posedge clock) begin
        if (rst) begin
            cksum <= 8'h00;
        end else if (rx_valid) begin
            if (state == P_WAIT_HDR) begin
                cksum <= 8'h00;
            end else begin
                cksum <= cksum ^ rx_shift;
            end
        end
    end
`endif

    // Frame parser. A received byte takes priority over a timeout in the
    // same cycle. Framing errors only matter while a load is active; in
    // IDLE, DONE and ERROR all receiver output is ignored.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= P_IDLE;
            start_prev <= 1'b0;
            prog_mode  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_wen    <= 1'b0;
            mem_sel    <= 1'b0;
            mem_adr    <= '0;
            mem_dat    <= '0;
            region     <= 1'b0;
            adr_lo     <= '0;
            cnt_lo     <= '0;
            adr_cnt    <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
        end else begin
            mem_wen    <= 1'b0;
            start_prev <= start_pg;
            case (state)
                P_IDLE: begin
                    if (start_pg) begin
                        state     <= P_WAIT_HDR;
                        prog_mode <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                P_DONE: begin
                    state <= P_IDLE;
                end
                P_ERROR: begin
                    if (start_pg && !start_prev) begin
                        state <= P_WAIT_HDR;
                        err   <= 1'b0;
                    end
                end
                default: begin
                    if (rx_ferr) begin
                        state <= P_ERROR;
                        err   <= 1'b1;
                    end else if (rx_valid) begin
                        case (state)
                            P_WAIT_HDR: begin
                                if (rx_shift == 8'hA5) begin
                                    state <= P_REGION;
                                end else if (rx_shift == 8'h5A) begin
                                    state     <= P_DONE;
                                    done      <= 1'b1;
                                    prog_mode <= 1'b0;
                                end else begin
                                    state <= P_ERROR;
                                    err   <= 1'b1;
                                end
                            end
                            P_REGION: begin
                                region <= rx_shift[0];
                                state  <= P_ADR_LO;
                            end
                            P_ADR_LO: begin
                                adr_lo <= rx_shift;
                                state  <= P_ADR_HI;
                            end
                            P_ADR_HI: begin
                                adr_cnt <= ADDR_W'({rx_shift, adr_lo});
                                state   <= P_CNT_LO;
                            end
                            P_CNT_LO: begin
                                cnt_lo <= rx_shift;
                                state  <= P_CNT_HI;
                            end
                            P_CNT_HI: begin
                                words_left <= {rx_shift, cnt_lo};
                                byte_idx   <= 2'd0;
                                if ({rx_shift, cnt_lo} == 16'd0) begin
                                    state <= END_STATE;
                                end else begin
                                    state <= P_DATA;
                                end
                            end
                            P_DATA: begin
                                byte_idx <= byte_idx + 1'b1;
                                if (byte_idx == 2'd3) begin
                                    mem_wen    <= 1'b1;
                                    mem_sel    <= region;
                                    mem_adr    <= adr_cnt;
                                    mem_dat    <= {rx_shift, word_buf};
                                    adr_cnt    <= adr_cnt + 1'b1;
                                    words_left <= words_left - 16'd1;
                                    if (words_left == 16'd1) begin
                                        state <= END_STATE;
                                    end
                                end else begin
                                    word_buf <= {rx_shift, word_buf[23:8]};
                                end
                            end
`ifdef UART_LOADER_CKSUM_EN
                            P_CKSUM: begin
                                if (rx_shift == cksum) begin
                                    state <= P_WAIT_HDR;
                                end else begin
                                    state <= P_ERROR;
                                    err   <= 1'b1;
                                end
                            end
`endif
                            default: begin
                                state <= P_ERROR;
                                err   <= 1'b1;
                            end
                        endcase
                    end else if (timeout) begin
                        state <= P_ERROR;
                        err   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Directed bench for uart_prog_loader. Frames are described at word level
// (region, base address, list of words); the bench derives the expected
// memory writes from that description and a separate process checks every
// cycle that writes match the expected list and that the write port holds
// its last value otherwise. Small parameters keep the run short.
// ---------------------------------------------------------------------------
module tb_uart_prog_loader;

    localparam int CPB = 8;
    localparam int AW  = 14;
    localparam int GAP = 3000;

    logic          clock = 1'b0;
    logic          rst;
    logic          rx;
    logic          start_pg;
    logic          prog_mode;
    logic          mem_wen;
    logic          mem_sel;
    logic [AW-1:0] mem_adr;
    logic [31:0]   mem_dat;
    logic          done;
    logic          err;

    typedef struct packed {
        logic          sel;
        logic [AW-1:0] adr;
        logic [31:0]   dat;
    } wr_t;

    wr_t           exp_q[$];
    logic [31:0]   frame_words[$];
    int            tests_run    = 0;
    int            tests_failed = 0;
    int            writes_seen  = 0;
    logic          armed        = 1'b0;
    logic          hold_sel     = 1'b0;
    logic [AW-1:0] hold_adr     = '0;
    logic [31:0]   hold_dat     = '0;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .rx       (rx),
        .start_pg (start_pg),
        .prog_mode(prog_mode),
        .mem_wen  (mem_wen),
        .mem_sel  (mem_sel),
        .mem_adr  (mem_adr),
        .mem_dat  (mem_dat),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drives one 8N1 byte, LSB first, starting and ending on a falling
    // clock edge. A bad stop bit is followed by idle line so the next
    // start bit still has a clean falling edge.
    task automatic applyStimulus(input logic [7:0] b, input logic good_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = good_stop;
        repeat (CPB) @(negedge clock);
        if (!good_stop) begin
            rx = 1'b1;
            repeat (2 * CPB) @(negedge clock);
        end
    endtask

    // Sends a complete frame built from frame_words and queues the writes
    // it must produce: consecutive word addresses modulo 2^AW.
    task automatic sendFrame(input logic [7:0] region, input logic [15:0] base);
        logic [7:0]  ck;
        logic [15:0] n;
        logic [31:0] w;
        wr_t         e;
        n = 16'(frame_words.size());
        for (int i = 0; i < frame_words.size(); i++) begin
            e.sel = region[0];
            e.adr = AW'((int'(base) + i) % (1 << AW));
            e.dat = frame_words[i];
            exp_q.push_back(e);
        end
        ck = region ^ base[7:0] ^ base[15:8] ^ n[7:0] ^ n[15:8];
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(region, 1'b1);
        applyStimulus(base[7:0], 1'b1);
        applyStimulus(base[15:8], 1'b1);
        applyStimulus(n[7:0], 1'b1);
        applyStimulus(n[15:8], 1'b1);
        for (int i = 0; i < frame_words.size(); i++) begin
            w = frame_words[i];
            for (int k = 0; k < 4; k++) begin
                applyStimulus(w[8*k +: 8], 1'b1);
                ck = ck ^ w[8*k +: 8];
            end
        end
`ifdef UART_LOADER_CKSUM_EN
        applyStimulus(ck, 1'b1);
`endif
    endtask

    // Per-cycle write-port checker, sampled 1 time unit after each rising
    // edge: a strobe must match the next expected write, otherwise the
    // port must hold the last written values (zero after reset).
    always @(posedge clock) begin
        wr_t e;
        #1;
        if (armed) begin
            if (rst) begin
                hold_sel = 1'b0;
                hold_adr = '0;
                hold_dat = '0;
            end
            if (mem_wen === 1'b1) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_write: got adr 0x%0h dat 0x%0h, expected no write",
                             mem_adr, mem_dat);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("write_sel", 32'(mem_sel), 32'(e.sel));
                    checkOutput("write_adr", 32'(mem_adr), 32'(e.adr));
                    checkOutput("write_dat", mem_dat, e.dat);
                    hold_sel = e.sel;
                    hold_adr = e.adr;
                    hold_dat = e.dat;
                end
            end else begin
                checkOutput("wen_idle", 32'(mem_wen), 32'd0);
                checkOutput("hold_sel", 32'(mem_sel), 32'(hold_sel));
                checkOutput("hold_adr", 32'(mem_adr), 32'(hold_adr));
                checkOutput("hold_dat", mem_dat, hold_dat);
            end
        end
    end

    initial begin
        int base_writes;
        rst      = 1'b1;
        rx       = 1'b1;
        start_pg = 1'b0;
        armed    = 1'b1;
        waitCycles(5);
        rst = 1'b0;
        waitCycles(2);

        // Reset values
        checkOutput("reset_prog_mode", 32'(prog_mode), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_mem_adr", 32'(mem_adr), 32'd0);
        checkOutput("reset_mem_dat", mem_dat, 32'd0);

        // Glitch while idle
        rx = 1'b0;
        waitCycles(1);
        rx = 1'b1;
        waitCycles(12 * CPB);
        checkOutput("idle_glitch_prog_mode", 32'(prog_mode), 32'd0);

        // Enter programming mode: prog_mode the cycle after start_pg
        start_pg = 1'b1;
        waitCycles(1);
        checkOutput("start_prog_mode", 32'(prog_mode), 32'd1);
        waitCycles(2);
        start_pg = 1'b0;

        // Glitch while waiting for a header must not produce a byte
        rx = 1'b0;
        waitCycles(1);
        rx = 1'b1;
        waitCycles(12 * CPB);
        checkOutput("hdr_glitch_err", 32'(err), 32'd0);

        // Two instruction words at 0x0010
        frame_words = '{32'h12345678, 32'hDEADBEEF};
        sendFrame(8'h00, 16'h0010);
        waitCycles(3);
        checkOutput("frame1_writes", 32'(writes_seen), 32'd2);
        checkOutput("frame1_last_adr", 32'(mem_adr), 32'h0011);
        checkOutput("frame1_last_dat", mem_dat, 32'hDEADBEEF);
        checkOutput("frame1_sel", 32'(mem_sel), 32'd0);

        // Empty frame: no write
        frame_words = {};
        sendFrame(8'h00, 16'h1234);
        waitCycles(3);
        checkOutput("empty_frame_writes", 32'(writes_seen), 32'd2);

        // Data region, address wraps from 0x3FFF to 0x0000
        frame_words = '{32'hCAFEF00D, 32'h0BADC0DE};
        sendFrame(8'h01, 16'h3FFF);
        waitCycles(3);
        checkOutput("wrap_adr", 32'(mem_adr), 32'h0000);
        checkOutput("wrap_sel", 32'(mem_sel), 32'd1);
        checkOutput("wrap_err", 32'(err), 32'd0);

        // Base bits above ADDR_W discarded, region bits 7:1 ignored
        frame_words = '{32'h55AA00FF};
        sendFrame(8'h03, 16'hC005);
        waitCycles(3);
        checkOutput("hibits_adr", 32'(mem_adr), 32'h0005);
        checkOutput("hibits_sel", 32'(mem_sel), 32'd1);

        // End of load
        applyStimulus(8'h5A, 1'b1);
        waitCycles(2);
        checkOutput("end_done", 32'(done), 32'd1);
        checkOutput("end_prog_mode", 32'(prog_mode), 32'd0);
        waitCycles(50);
        checkOutput("done_holds", 32'(done), 32'd1);

        // Framing error on the 3rd payload byte
        start_pg = 1'b1;
        waitCycles(1);
        checkOutput("restart_done_cleared", 32'(done), 32'd0);
        start_pg = 1'b0;
        base_writes = writes_seen;
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h20, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b0);
        checkOutput("ferr_err", 32'(err), 32'd1);
        checkOutput("ferr_prog_mode", 32'(prog_mode), 32'd1);
        applyStimulus(8'h44, 1'b1);
        waitCycles(3);
        checkOutput("ferr_no_write", 32'(writes_seen), 32'(base_writes));
        start_pg = 1'b1;
        waitCycles(1);
        checkOutput("ferr_clear_err", 32'(err), 32'd0);
        checkOutput("ferr_clear_prog_mode", 32'(prog_mode), 32'd1);
        start_pg = 1'b0;
        frame_words = '{32'h01020304};
        sendFrame(8'h00, 16'h0100);
        applyStimulus(8'h5A, 1'b1);
        waitCycles(2);
        checkOutput("recover_done", 32'(done), 32'd1);
        checkOutput("recover_adr", 32'(mem_adr), 32'h0100);

        // Inter-byte timeout after the count bytes
        start_pg = 1'b1;
        waitCycles(2);
        start_pg = 1'b0;
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b1);
        waitCycles(GAP - 200);
        checkOutput("gap_before_timeout", 32'(err), 32'd0);
        waitCycles(400);
        checkOutput("gap_timeout_err", 32'(err), 32'd1);
        checkOutput("gap_timeout_prog_mode", 32'(prog_mode), 32'd1);

        // Reset in the middle of a word
        start_pg = 1'b1;
        waitCycles(1);
        start_pg = 1'b0;
        base_writes = writes_seen;
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h05, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'hBB, 1'b1);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("rst_prog_mode", 32'(prog_mode), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_mem_adr", 32'(mem_adr), 32'd0);
        checkOutput("rst_mem_sel", 32'(mem_sel), 32'd0);
        waitCycles(2);
        rst = 1'b0;
        applyStimulus(8'hCC, 1'b1);
        applyStimulus(8'hDD, 1'b1);
        waitCycles(3);
        checkOutput("rst_no_write", 32'(writes_seen), 32'(base_writes));
        checkOutput("rst_idle_prog_mode", 32'(prog_mode), 32'd0);

`ifdef UART_LOADER_CKSUM_EN
        // Checksum trailer: 0x05 accepted, 0x06 rejected after the write
        start_pg = 1'b1;
        waitCycles(2);
        start_pg = 1'b0;
        exp_q.push_back('{sel: 1'b0, adr: '0, dat: 32'h04030201});
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h04, 1'b1);
        applyStimulus(8'h05, 1'b1);
        waitCycles(3);
        checkOutput("cksum_good_err", 32'(err), 32'd0);
        base_writes = writes_seen;
        exp_q.push_back('{sel: 1'b0, adr: '0, dat: 32'h04030201});
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h04, 1'b1);
        applyStimulus(8'h06, 1'b1);
        waitCycles(3);
        checkOutput("cksum_bad_err", 32'(err), 32'd1);
        checkOutput("cksum_bad_written", 32'(writes_seen), 32'(base_writes + 1));
`endif

        waitCycles(20);
        checkOutput("expected_writes_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
